alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that sits on the driving side of the 32-bit ALU. It accepts an operation request (main-control ALUOp plus funct, operands A/B) over a valid/ready handshake and decodes it to the 3-bit ALU select. It holds the ALU inputs stable for a per-operation number of cycles, then captures R and ZF. It returns them over a valid/ready response handshake to the datapath/branch unit.

Parameters:
WIDTH, 32, operand/result width
SETTLE_CYCLES, 1, EXEC cycles for add/sub/and/or/slt/passB (must be >=1)
MULDIV_CYCLES, 4, EXEC cycles for mul/div (must be >=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_aluop  in  2  main-control class: 00 add, 01 sub, 10 R-type (use funct), 11 slt
req_funct  in  6  R-type funct field, used only when req_aluop=10
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
alu_a  out  WIDTH  registered ALU operand A
alu_b  out  WIDTH  registered ALU operand B
alu_sel  out  3  registered ALU select
alu_r  in  WIDTH  ALU result
alu_zf  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_r  out  WIDTH  captured result
rsp_zf  out  1  captured zero flag
rsp_err  out  1  illegal funct (or div-by-zero, see feature)

Behaviour:
- Single clock; reset is asynchronous and active-low: rst_n low immediately forces state IDLE, req_ready=1 once released, all other outputs 0 (alu_sel=0, rsp_valid=0, rsp_r=0, rsp_zf=0, rsp_err=0, counter=0).
- Decode: aluop 00->sel 0, 01->1, 11->4. For aluop 10, funct 0x20->0 add, 0x22->1 sub, 0x24->2 and, 0x25->3 or, 0x2A->4 slt, 0x18->5 mul, 0x1A->6 div, 0x00->7 passB. Any other funct is illegal.
- FSM states IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register req_a/req_b into alu_a/alu_b and the decoded value into alu_sel.
  - Legal: load the counter with N-1, where N=MULDIV_CYCLES for sel 5/6 and SETTLE_CYCLES otherwise. Go to EXEC.
  - Illegal: alu_* unchanged; set rsp_r=0, rsp_zf=0, rsp_err=1, rsp_valid=1. Go to RESP directly.
- EXEC: req_ready=0. alu_a/alu_b/alu_sel are held constant. Decrement the counter each cycle. On the cycle the counter equals 0, capture rsp_r<=alu_r, rsp_zf<=alu_zf, rsp_err<=0, rsp_valid<=1, and go to RESP.
- Latency: accept at edge T, response valid after edge T+N. Illegal requests respond after edge T.
- RESP: req_ready=0. rsp_* are held stable while rsp_valid&&!rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE. rsp_r/rsp_zf/rsp_err keep their last value.
- Throughput: one request per N+2 cycles minimum, with a one-cycle IDLE bubble after each response. req_valid during EXEC/RESP is ignored, not queued.
- Widths: alu_r and rsp_r are WIDTH bits with no extension or truncation inside the block. ZF comes from the ALU, not recomputed.
- Reset asserted mid-EXEC or in RESP: the in-flight operation is dropped with no response.

Optional Feature:
DIV0_CHECK_EN. When defined, a div request (sel 6) with req_b==0 skips EXEC and goes straight to RESP with rsp_r={WIDTH{1}}, rsp_zf=0, rsp_err=1, one-cycle latency like an illegal funct. When undefined, div by zero is issued normally and rsp_err=0; the result is whatever the ALU produces.

Decomposition:
- Package alu_pkg: ALU select constants (SEL_ADD..SEL_PASSB), funct codes, ALUOp codes, FSM state enum.
- Sub-module alu_funct_dec: combinational {aluop, funct} -> {sel, illegal, is_long}, reused later by the main control unit.

Test Plan:
- Reset with all inputs 0 -> req_ready=1 after release; rsp_valid=0, alu_sel=0, rsp_r=0.
- aluop=10 funct=0x20, A=5, B=7, rsp_ready=1 -> alu_sel=0 for 1 EXEC cycle; rsp_r=12, rsp_zf=0, rsp_err=0 one edge after accept+1.
- aluop=01, A=9, B=9 (beq) -> rsp_r=0, rsp_zf=1. funct=0x2A, A=3, B=8 -> rsp_r=1.
- funct=0x18, A=6, B=7 -> alu_a/alu_b/alu_sel stable for exactly 4 EXEC cycles; rsp_r=42. Then hold rsp_ready=0 for 3 cycles -> rsp_* unchanged and req_ready=0 throughout.
- funct=0x3F -> rsp_err=1, rsp_r=0 one cycle after accept; alu_sel keeps its previous value.
- With DIV0_CHECK_EN: funct=0x1A, B=0 -> rsp_r=0xFFFFFFFF, rsp_err=1. Also assert rst_n=0 mid-EXEC of a mul -> rsp_valid stays 0 and state returns to IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU select codes, funct/ALUOp encodings and issue FSM states
// shared by the ALU issue controller and the main control decoder.
package alu_pkg;

   typedef logic [2:0] alu_sel_t;

   localparam alu_sel_t SEL_ADD   = 3'd0;
   localparam alu_sel_t SEL_SUB   = 3'd1;
   localparam alu_sel_t SEL_AND   = 3'd2;
   localparam alu_sel_t SEL_OR    = 3'd3;
   localparam alu_sel_t SEL_SLT   = 3'd4;
   localparam alu_sel_t SEL_MUL   = 3'd5;
   localparam alu_sel_t SEL_DIV   = 3'd6;
   localparam alu_sel_t SEL_PASSB = 3'd7;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_MUL   = 6'h18;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_PASSB = 6'h00;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_SLT   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // mul/div use the long settle budget
   function automatic logic sel_is_long(input alu_sel_t s);
      return (s == SEL_MUL) || (s == SEL_DIV);
   endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// ALU operation decoder: {aluop, funct} -> {sel, illegal, is_long}.
// Ports: i_aluop, i_funct in; o_sel, o_illegal, o_is_long out (comb).
module alu_funct_dec
   import alu_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [5:0] i_funct,
   output alu_sel_t   o_sel,
   output logic       o_illegal,
   output logic       o_is_long
);

   always_comb begin
      o_sel     = SEL_ADD;
      o_illegal = 1'b0;
      unique case (i_aluop)
         OP_ADD: o_sel = SEL_ADD;
         OP_SUB: o_sel = SEL_SUB;
         OP_SLT: o_sel = SEL_SLT;
         OP_RTYPE: begin
            case (i_funct)
               FN_ADD:   o_sel = SEL_ADD;
               FN_SUB:   o_sel = SEL_SUB;
               FN_AND:   o_sel = SEL_AND;
               FN_OR:    o_sel = SEL_OR;
               FN_SLT:   o_sel = SEL_SLT;
               FN_MUL:   o_sel = SEL_MUL;
               FN_DIV:   o_sel = SEL_DIV;
               FN_PASSB: o_sel = SEL_PASSB;
               default:  o_illegal = 1'b1;
            endcase
         end
      endcase
      o_is_long = !o_illegal && sel_is_long(o_sel);
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: request handshake -> decode ->
// hold ALU inputs N cycles -> capture R/ZF -> response handshake.
// Ports: clk, rst_n; req_* request channel; alu_a/alu_b/alu_sel out
// to the ALU, alu_r/alu_zf back; rsp_* response channel.
// Option: define DIV0_CHECK_EN to answer div-by-zero with an error.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 1,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_aluop,
   input  logic [5:0]       req_funct,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_zf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_r,
   output logic             rsp_zf,
   output logic             rsp_err
);

   localparam int MAXN =
      (SETTLE_CYCLES > MULDIV_CYCLES) ? SETTLE_CYCLES : MULDIV_CYCLES;
   localparam int CW = (MAXN > 1) ? $clog2(MAXN) : 1;

   localparam logic [CW-1:0] LD_SHORT = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] LD_LONG  = CW'(MULDIV_CYCLES - 1);

   state_t           r_state, w_nxt_state;
   logic [CW-1:0]    r_cnt, w_nxt_cnt;
   logic [WIDTH-1:0] r_alu_a, w_nxt_alu_a;
   logic [WIDTH-1:0] r_alu_b, w_nxt_alu_b;
   alu_sel_t         r_alu_sel, w_nxt_alu_sel;
   logic             r_rsp_valid, w_nxt_rsp_valid;
   logic [WIDTH-1:0] r_rsp_r, w_nxt_rsp_r;
   logic             r_rsp_zf, w_nxt_rsp_zf;
   logic             r_rsp_err, w_nxt_rsp_err;

   alu_sel_t w_dec_sel;
   logic     w_dec_illegal;
   logic     w_dec_long;

   alu_funct_dec u_dec (
      .i_aluop   (req_aluop),
      .i_funct   (req_funct),
      .o_sel     (w_dec_sel),
      .o_illegal (w_dec_illegal),
      .o_is_long (w_dec_long)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= SEL_ADD;
         r_rsp_valid <= 1'b0;
         r_rsp_r     <= '0;
         r_rsp_zf    <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_cnt       <= w_nxt_cnt;
         r_alu_a     <= w_nxt_alu_a;
         r_alu_b     <= w_nxt_alu_b;
         r_alu_sel   <= w_nxt_alu_sel;
         r_rsp_valid <= w_nxt_rsp_valid;
         r_rsp_r     <= w_nxt_rsp_r;
         r_rsp_zf    <= w_nxt_rsp_zf;
         r_rsp_err   <= w_nxt_rsp_err;
      end
   end

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_cnt       = r_cnt;
      w_nxt_alu_a     = r_alu_a;
      w_nxt_alu_b     = r_alu_b;
      w_nxt_alu_sel   = r_alu_sel;
      w_nxt_rsp_valid = r_rsp_valid;
      w_nxt_rsp_r     = r_rsp_r;
      w_nxt_rsp_zf    = r_rsp_zf;
      w_nxt_rsp_err   = r_rsp_err;
      unique case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_dec_illegal) begin
                  // ALU inputs stay as they were
                  w_nxt_rsp_r     = '0;
                  w_nxt_rsp_zf    = 1'b0;
                  w_nxt_rsp_err   = 1'b1;
                  w_nxt_rsp_valid = 1'b1;
                  w_nxt_state     = ST_RESP;
               end
`ifdef DIV0_CHECK_EN
               else if (w_dec_sel == SEL_DIV && req_b == '0) begin
                  w_nxt_alu_a     = req_a;
                  w_nxt_alu_b     = req_b;
                  w_nxt_alu_sel   = w_dec_sel;
                  w_nxt_rsp_r     = '1;
                  w_nxt_rsp_zf    = 1'b0;
                  w_nxt_rsp_err   = 1'b1;
                  w_nxt_rsp_valid = 1'b1;
                  w_nxt_state     = ST_RESP;
               end
`endif
               else begin
                  w_nxt_alu_a   = req_a;
                  w_nxt_alu_b   = req_b;
                  w_nxt_alu_sel = w_dec_sel;
                  w_nxt_cnt     = w_dec_long ? LD_LONG : LD_SHORT;
                  w_nxt_state   = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (r_cnt == '0) begin
               w_nxt_rsp_r     = alu_r;
               w_nxt_rsp_zf    = alu_zf;
               w_nxt_rsp_err   = 1'b0;
               w_nxt_rsp_valid = 1'b1;
               w_nxt_state     = ST_RESP;
            end else begin
               w_nxt_cnt = r_cnt - CW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_nxt_rsp_valid = 1'b0;
               w_nxt_state     = ST_IDLE;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   assign req_ready = (r_state == ST_IDLE);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign rsp_valid = r_rsp_valid;
   assign rsp_r     = r_rsp_r;
   assign rsp_zf    = r_rsp_zf;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a
// behavioural ALU on the driving side and a spec-level reference.
module tb_alu_issue_ctrl;

   localparam int W      = 32;
   localparam int SETTLE = 1;
   localparam int MULDIV = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_aluop;
   logic [5:0]   req_funct;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [2:0]   alu_sel;
   logic [W-1:0] alu_r;
   logic         alu_zf;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_r;
   logic         rsp_zf;
   logic         rsp_err;

   int vectors = 0;
   int miscompares = 0;
   logic [2:0] m_sel;

   always #5 clk = ~clk;

   alu_issue_ctrl #(
      .WIDTH         (W),
      .SETTLE_CYCLES (SETTLE),
      .MULDIV_CYCLES (MULDIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_aluop (req_aluop),
      .req_funct (req_funct),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_r     (alu_r),
      .alu_zf    (alu_zf),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_r     (rsp_r),
      .rsp_zf    (rsp_zf),
      .rsp_err   (rsp_err)
   );

   // behavioural 32-bit ALU the controller drives
   always_comb begin
      alu_r = '0;
      case (alu_sel)
         3'd0: alu_r = alu_a + alu_b;
         3'd1: alu_r = alu_a - alu_b;
         3'd2: alu_r = alu_a & alu_b;
         3'd3: alu_r = alu_a | alu_b;
         3'd4: alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
         3'd5: alu_r = alu_a * alu_b;
         3'd6: alu_r = (alu_b == 0) ? '1 : alu_a / alu_b;
         default: alu_r = alu_b;
      endcase
      alu_zf = (alu_r == 0);
   end

   // reference: expected result, flags, latency and select (-1 = illegal)
   task automatic ref_op(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic zf,
                         output logic err, output int lat, output int sel);
      sel = -1;
      case (op)
         2'b00: sel = 0;
         2'b01: sel = 1;
         2'b11: sel = 4;
         default: begin
            case (fn)
               6'h20: sel = 0;
               6'h22: sel = 1;
               6'h24: sel = 2;
               6'h25: sel = 3;
               6'h2A: sel = 4;
               6'h18: sel = 5;
               6'h1A: sel = 6;
               6'h00: sel = 7;
               default: sel = -1;
            endcase
         end
      endcase
      case (sel)
         0: r = a + b;
         1: r = a - b;
         2: r = a & b;
         3: r = a | b;
         4: r = ($signed(a) < $signed(b)) ? 1 : 0;
         5: r = a * b;
         6: r = (b == 0) ? {W{1'b1}} : a / b;
         7: r = b;
         default: r = '0;
      endcase
      err = (sel < 0);
      zf  = !err && (r == 0);
      lat = err ? 0 : ((sel == 5 || sel == 6) ? MULDIV : SETTLE);
`ifdef DIV0_CHECK_EN
      if (sel == 6 && b == 0) begin
         r   = '1;
         zf  = 1'b0;
         err = 1'b1;
         lat = 0;
      end
`endif
   endtask

   // one full transaction from IDLE back to IDLE, junk req_valid while busy
   task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
      logic [W-1:0] er;
      logic ezf, eerr;
      int elat, esel, cyc;
      ref_op(op, fn, a, b, er, ezf, eerr, elat, esel);
      req_aluop = op;
      req_funct = fn;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_ready op=%0d fn=%h got=%b want=1",
                  op, fn, req_ready);
      end
      @(posedge clk); #1;
      if (esel >= 0) m_sel = esel[2:0];
      req_aluop = 2'b10;
      req_funct = 6'h20;
      req_a     = $urandom;
      req_b     = $urandom;
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 40) begin
         vectors++;
         if (alu_a !== a || alu_b !== b || alu_sel !== m_sel ||
             req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL exec_hold cyc=%0d a=%h b=%h sel=%0d rdy=%b want a=%h b=%h sel=%0d rdy=0",
                     cyc, alu_a, alu_b, alu_sel, req_ready, a, b, m_sel);
         end
         @(posedge clk); #1;
         cyc++;
      end
      vectors++;
      if (cyc != elat) begin
         miscompares++;
         $display("FAIL latency op=%0d fn=%h got=%0d want=%0d",
                  op, fn, cyc, elat);
      end
      vectors++;
      if (rsp_r !== er || rsp_zf !== ezf || rsp_err !== eerr) begin
         miscompares++;
         $display("FAIL rsp op=%0d fn=%h a=%h b=%h got r=%h zf=%b err=%b want r=%h zf=%b err=%b",
                  op, fn, a, b, rsp_r, rsp_zf, rsp_err, er, ezf, eerr);
      end
      vectors++;
      if (alu_sel !== m_sel) begin
         miscompares++;
         $display("FAIL alu_sel got=%0d want=%0d", alu_sel, m_sel);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_r !== er || rsp_err !== eerr ||
             rsp_zf !== ezf || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_hold i=%0d v=%b r=%h rdy=%b want v=1 r=%h rdy=0",
                     i, rsp_valid, rsp_r, req_ready, er);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_r !== er) begin
         miscompares++;
         $display("FAIL release v=%b rdy=%b r=%h want v=0 rdy=1 r=%h",
                  rsp_valid, req_ready, rsp_r, er);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_aluop = '0;
      req_funct = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      m_sel     = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (rsp_valid !== 1'b0 || alu_sel !== 3'd0 || rsp_r !== '0 ||
          rsp_err !== 1'b0 || rsp_zf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outs v=%b sel=%0d r=%h err=%b zf=%b want 0",
                  rsp_valid, alu_sel, rsp_r, rsp_err, rsp_zf);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release rdy=%b v=%b want rdy=1 v=0",
                  req_ready, rsp_valid);
      end
   endtask

   task automatic test_directed();
      do_op(2'b10, 6'h20, 32'd5, 32'd7, 0);
      do_op(2'b01, 6'h00, 32'd9, 32'd9, 0);
      do_op(2'b10, 6'h2A, 32'd3, 32'd8, 0);
      do_op(2'b10, 6'h18, 32'd6, 32'd7, 3);
      do_op(2'b10, 6'h3F, 32'd1, 32'd2, 1);
      do_op(2'b10, 6'h1A, 32'd100, 32'd0, 0);
      do_op(2'b10, 6'h1A, 32'd100, 32'd7, 0);
      do_op(2'b10, 6'h00, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      do_op(2'b00, 6'h3F, 32'hFFFF_FFFF, 32'd1, 0);
   endtask

   task automatic test_random();
      logic [5:0] legal [8];
      logic [5:0] fn;
      logic [W-1:0] b;
      logic [1:0] op;
      legal = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h00};
      for (int n = 0; n < 60; n++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
         else fn = legal[$urandom_range(0, 7)];
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = '0;
         do_op(op, fn, $urandom, b, $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid_exec();
      req_aluop = 2'b10;
      req_funct = 6'h18;
      req_a     = 32'd11;
      req_b     = 32'd13;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      m_sel = 3'd0;
      vectors++;
      if (rsp_valid !== 1'b0 || alu_sel !== 3'd0 || alu_a !== '0 ||
          req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid v=%b sel=%0d a=%h rdy=%b want 0/0/0/1",
                  rsp_valid, alu_sel, alu_a, req_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_drop i=%0d v=%b rdy=%b want v=0 rdy=1",
                     i, rsp_valid, req_ready);
         end
      end
      do_op(2'b10, 6'h22, 32'd50, 32'd8, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++)
         do_op(2'b10, (n % 2 == 0) ? 6'h18 : 6'h24,
               $urandom, $urandom, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid_exec();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
